// File: rtl/echo_rx_one_ch_if.sv
// Echo sample stream between the receive channel and its consumer.
// Valid/ready handshake; a sample moves on a cycle where both are high.
interface echo_rx_one_ch_if #(
   parameter int DATA_W = 10
) ();
   logic [DATA_W-1:0] Echo_Data;
   logic              Echo_Valid;
   logic              Echo_Ready;
   logic              Echo_Last;

   modport master (output Echo_Data, output Echo_Valid, output Echo_Last, input Echo_Ready);
   modport slave  (input Echo_Data, input Echo_Valid, input Echo_Last, output Echo_Ready);
endinterface

// File: rtl/echo_rx_one_ch.sv
// Single-channel echo receiver: waits RecvDelay cycles after a rising
// RX_Gate edge, captures Recv_Length ADC samples into a FWFT FIFO and tags
// the final one Last. Optional pair averaging is enabled by defining
// RECV_DECIM2_EN.
module echo_rx_one_ch #(
   parameter int DATA_W     = 10,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 10
) (
   input  logic               Receive_CLK,
   input  logic               Rst_n,
   input  logic               RX_Gate,
   input  logic [7:0]         RecvDelay,
   input  logic [LEN_W-1:0]   Recv_Length,
   input  logic [DATA_W-1:0]  ADC_Data,
   echo_rx_one_ch_if.master   echo,
   output logic               Recv_Busy,
   output logic               Recv_Overflow
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, DONE} state_e;

   state_e            st_q, st_d;
   logic              gate_d_q, gate_d_d;   // RX_Gate delayed one cycle
   logic [6:0]        dcfg_q, dcfg_d;       // delay latched at start
   logic [LEN_W-1:0]  len_q, len_d;         // length latched at start
   logic [6:0]        dly_q, dly_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;         // output samples produced (incl. dropped)
   logic              ovf_q, ovf_d;
   logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
   logic [DATA_W:0]   mem_q [FIFO_DEPTH];   // {last, data}

   logic              start, start_acq, cap_en;
   logic              smp_push, smp_last;
   logic [DATA_W-1:0] smp_data;
   logic              empty, full, pop, push_ok;

   assign start  = RX_Gate & ~gate_d_q;
   // ADC sample is taken this edge: the delay just expired or we are mid-capture
   assign cap_en = RX_Gate & (((st_q == DELAY) && (dly_q == dcfg_q)) || (st_q == CAPTURE));

`ifdef RECV_DECIM2_EN
   logic              phase_q, phase_d;     // 1 = first sample of pair held
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W:0]   pair_sum;

   assign pair_sum = {1'b0, hold_q} + {1'b0, ADC_Data};

   // Pair up captured samples and emit their truncated mean on the second one
   always_comb begin
      phase_d  = phase_q;
      hold_d   = hold_q;
      smp_push = 1'b0;
      smp_data = pair_sum[DATA_W:1];
      if (start_acq) begin
         phase_d = 1'b0;
      end else if (cap_en) begin
         if (!phase_q) begin
            hold_d  = ADC_Data;
            phase_d = 1'b1;
         end else begin
            phase_d  = 1'b0;
            smp_push = 1'b1;
         end
      end
   end

   // Pair accumulator registers
   always_ff @(posedge Receive_CLK) begin
      if (!Rst_n) begin
         phase_q <= 1'b0;
         hold_q  <= '0;
      end else begin
         phase_q <= phase_d;
         hold_q  <= hold_d;
      end
   end
`else
   assign smp_push = cap_en;
   assign smp_data = ADC_Data;
`endif

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop     = ~empty & echo.Echo_Ready;
   assign push_ok = smp_push & (~full | pop);

   // Acquisition FSM, counters and sticky overflow
   always_comb begin
      st_d      = st_q;
      gate_d_d  = RX_Gate;
      dcfg_d    = dcfg_q;
      len_d     = len_q;
      dly_d     = dly_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      start_acq = 1'b0;
      smp_last  = 1'b0;
      case (st_q)
         IDLE: begin
            if (start) begin
               ovf_d  = 1'b0;
               dcfg_d = RecvDelay[6:0];
               len_d  = Recv_Length;
               dly_d  = '0;
               cnt_d  = '0;
               if (RecvDelay[7] || (Recv_Length == '0)) begin
                  st_d = DONE;
               end else begin
                  st_d      = DELAY;
                  start_acq = 1'b1;
               end
            end
         end
         DELAY: begin
            if (!RX_Gate)              st_d = IDLE;
            else if (dly_q == dcfg_q)  st_d = CAPTURE;
            else                       dly_d = dly_q + 7'd1;
         end
         CAPTURE: begin
            if (!RX_Gate) st_d = IDLE;
         end
         DONE: begin
            if (!RX_Gate) st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
      // A dropped sample still counts so the window length never stretches
      if (smp_push) begin
         cnt_d = cnt_q + LEN_W'(1);
         if (cnt_q == len_q - LEN_W'(1)) begin
            smp_last = 1'b1;
            st_d     = DONE;
         end
         if (!push_ok) ovf_d = 1'b1;
      end
   end

   // FIFO pointer update; pointers carry one extra wrap bit
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop)     rd_d = rd_q + 1'b1;
   end

   // State and control registers
   always_ff @(posedge Receive_CLK) begin
      if (!Rst_n) begin
         st_q     <= IDLE;
         gate_d_q <= 1'b1;
         dcfg_q   <= '0;
         len_q    <= '0;
         dly_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         wr_q     <= '0;
         rd_q     <= '0;
      end else begin
         st_q     <= st_d;
         gate_d_q <= gate_d_d;
         dcfg_q   <= dcfg_d;
         len_q    <= len_d;
         dly_q    <= dly_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
      end
   end

   // Sample storage; contents are don't-care once pointers are flushed
   always_ff @(posedge Receive_CLK) begin
      if (push_ok) mem_q[wr_q[AW-1:0]] <= {smp_last, smp_data};
   end

   assign echo.Echo_Valid = ~empty;
   assign echo.Echo_Data  = empty ? '0 : mem_q[rd_q[AW-1:0]][DATA_W-1:0];
   assign echo.Echo_Last  = ~empty & mem_q[rd_q[AW-1:0]][DATA_W];
   assign Recv_Busy       = (st_q == DELAY) || (st_q == CAPTURE);
   assign Recv_Overflow   = ovf_q;
endmodule

// File: tb/tb_echo_rx_one_ch.sv
// Bench for echo_rx_one_ch: edge-count based reference model with a
// per-cycle compare, plus directed scenarios with literal expectations.
// Define RECV_DECIM2_EN for both bench and RTL to exercise pair averaging.
module tb_echo_rx_one_ch;
   localparam int DW = 10, DEPTH = 16, LW = 10;

   logic          clk = 1'b0, rst_n = 1'b0, gate = 1'b0, ramp = 1'b0;
   logic [7:0]    dly = '0;
   logic [LW-1:0] len = '0;
   logic [DW-1:0] adc = '0;
   logic          busy, ovf;

   echo_rx_one_ch_if #(.DATA_W(DW)) eif ();

   echo_rx_one_ch #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
      .Receive_CLK(clk), .Rst_n(rst_n), .RX_Gate(gate), .RecvDelay(dly),
      .Recv_Length(len), .ADC_Data(adc), .echo(eif.master),
      .Recv_Busy(busy), .Recv_Overflow(ovf)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (ramp) adc = adc + 1'b1;
   endtask

   typedef struct {logic [DW-1:0] d; logic l;} ent_t;

   // Reference model: an acquisition is "edge count since start"; sample k of
   // the window is taken at edge D+1+k. FIFO is a bounded queue.
   ent_t          mq[$];
   int            m_run = 0, m_edge = 0, m_D = 0, m_L = 0, m_k = 0;
   bit            m_gd = 1'b1, m_ovf = 1'b0, m_pop, m_st, m_pu;
   logic [DW-1:0] m_hold = '0;
   ent_t          m_e;

   always @(posedge clk) begin
      m_pop = (mq.size() > 0) && eif.Echo_Ready;
      m_st  = gate && !m_gd;
      m_pu  = 1'b0;
      if (!rst_n) begin
         mq.delete();
         m_run = 0; m_gd = 1'b1; m_ovf = 1'b0;
      end else begin
         case (m_run)
            0: if (m_st) begin
                  m_ovf = 1'b0;
                  if (dly[7] || len == 0) m_run = 2;
                  else begin m_run = 1; m_edge = 0; m_D = int'(dly[6:0]); m_L = int'(len); end
               end
            1: begin
                  m_edge++;
                  if (!gate) m_run = 0;
                  else begin
                     m_k = m_edge - (m_D + 1);
`ifdef RECV_DECIM2_EN
                     if (m_k >= 0) begin
                        if (m_k % 2 == 0) m_hold = adc;
                        else begin
                           m_pu = 1'b1;
                           m_e.d = DW'((int'(m_hold) + int'(adc)) / 2);
                           m_e.l = (m_k / 2 == m_L - 1);
                        end
                     end
`else
                     if (m_k >= 0) begin
                        m_pu = 1'b1; m_e.d = adc; m_e.l = (m_k == m_L - 1);
                     end
`endif
                     if (m_pu && m_e.l) m_run = 2;
                  end
               end
            default: if (!gate) m_run = 0;
         endcase
         if (m_pop) void'(mq.pop_front());
         if (m_pu) begin
            if (mq.size() < DEPTH) mq.push_back(m_e);
            else m_ovf = 1'b1;
         end
         m_gd = gate;
      end
   end

   // Per-cycle compare against the model; also logs every DUT transfer
   bit   chk_en = 1'b0;
   ent_t got[$];
   ent_t g;
   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", 32'(eif.Echo_Valid), 32'(mq.size() > 0));
         if (mq.size() > 0) begin
            chk("data", 32'(eif.Echo_Data), 32'(mq[0].d));
            chk("last", 32'(eif.Echo_Last), 32'(mq[0].l));
         end
         chk("busy", 32'(busy), 32'(m_run == 1));
         chk("ovf", 32'(ovf), 32'(m_ovf));
         if (eif.Echo_Valid && eif.Echo_Ready) begin
            g.d = eif.Echo_Data; g.l = eif.Echo_Last;
            got.push_back(g);
         end
      end
   end

   function automatic logic [31:0] got_d(input int i);
      return (i < got.size()) ? 32'(got[i].d) : 32'hxxxxxxxx;
   endfunction
   function automatic logic [31:0] got_l(input int i);
      return (i < got.size()) ? 32'(got[i].l) : 32'hxxxxxxxx;
   endfunction

   initial begin
      eif.Echo_Ready = 1'b0;
      tick(); tick();
      chk_en = 1'b1;
      chk("rst_valid", 32'(eif.Echo_Valid), 0);
      chk("rst_data", 32'(eif.Echo_Data), 0);
      chk("rst_last", 32'(eif.Echo_Last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ovf", 32'(ovf), 0);
      rst_n = 1'b1;
      tick();

`ifdef RECV_DECIM2_EN
      // pairs (10,20) and (31,41) -> 15, 36 Last
      got.delete(); dly = 8'd0; len = 10'd2; eif.Echo_Ready = 1'b1; adc = '0; gate = 1'b1;
      tick(); adc = 10'd10; tick(); adc = 10'd20; tick(); adc = 10'd31; tick(); adc = 10'd41; tick();
      repeat (3) tick();
      gate = 1'b0; tick(); tick();
      chk("dec_n", got.size(), 2);
      chk("dec_d0", got_d(0), 15); chk("dec_l0", got_l(0), 0);
      chk("dec_d1", got_d(1), 36); chk("dec_l1", got_l(1), 1);
`else
      // delay 3, length 4 on a ramp -> 4,5,6,7 with Last on 7
      got.delete(); dly = 8'd3; len = 10'd4; eif.Echo_Ready = 1'b1; adc = '0; ramp = 1'b1; gate = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t1_busy", 32'(busy), 32'(i < 7));
      end
      repeat (4) tick();
      gate = 1'b0; ramp = 1'b0; tick(); tick();
      chk("t1_n", got.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_d", got_d(i), 32'(4 + i));
         chk("t1_l", got_l(i), 32'(i == 3));
      end

      // disabled channel: straight to DONE, nothing out, never busy
      got.delete(); dly = 8'h85; len = 10'd4; adc = '0; ramp = 1'b1; gate = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t2_busy", 32'(busy), 0);
         chk("t2_valid", 32'(eif.Echo_Valid), 0);
      end
      gate = 1'b0; ramp = 1'b0; tick(); tick();
      chk("t2_n", got.size(), 0);

      // overflow: 20 samples into 16 slots with no reader, then drain
      got.delete(); dly = 8'd0; len = 10'd20; eif.Echo_Ready = 1'b0; adc = '0; ramp = 1'b1; gate = 1'b1;
      repeat (25) tick();
      chk("t3_ovf", 32'(ovf), 1);
      chk("t3_head", 32'(eif.Echo_Data), 1);
      eif.Echo_Ready = 1'b1;
      repeat (20) tick();
      gate = 1'b0; ramp = 1'b0; tick(); tick();
      chk("t3_n", got.size(), 16);
      chk("t3_first", got_d(0), 1);
      chk("t3_lastv", got_d(15), 16);
      for (int i = 0; i < 16; i++) chk("t3_l", got_l(i), 0);
      chk("t3_ovf_sticky", 32'(ovf), 1);

      // abort after 2 of 10 samples, then a fresh run
      got.delete(); dly = 8'd0; len = 10'd10; adc = '0; ramp = 1'b1; gate = 1'b1;
      tick();
      chk("t4_ovf_clr", 32'(ovf), 0);
      tick(); tick();
      gate = 1'b0; tick();
      chk("t4_busy", 32'(busy), 0);
      tick(); tick();
      chk("t4_n", got.size(), 2);
      chk("t4_d0", got_d(0), 1); chk("t4_d1", got_d(1), 2);
      chk("t4_l1", got_l(1), 0);
      got.delete(); dly = 8'd1; len = 10'd2; adc = '0; gate = 1'b1;
      repeat (8) tick();
      gate = 1'b0; ramp = 1'b0; tick();
      chk("t4b_n", got.size(), 2);
      chk("t4b_d0", got_d(0), 2); chk("t4b_d1", got_d(1), 3);
      chk("t4b_l1", got_l(1), 1);

      // reset mid-capture with 3 samples buffered
      got.delete(); dly = 8'd0; len = 10'd10; eif.Echo_Ready = 1'b0; adc = '0; ramp = 1'b1; gate = 1'b1;
      repeat (4) tick();
      chk("t5_pre_valid", 32'(eif.Echo_Valid), 1);
      rst_n = 1'b0; tick();
      chk("t5_valid", 32'(eif.Echo_Valid), 0);
      chk("t5_data", 32'(eif.Echo_Data), 0);
      chk("t5_busy", 32'(busy), 0);
      rst_n = 1'b1; eif.Echo_Ready = 1'b1;
      repeat (6) tick();
      chk("t5_quiet", got.size(), 0);
      gate = 1'b0; tick();
      dly = 8'd0; len = 10'd1; adc = '0; gate = 1'b1;
      repeat (4) tick();
      gate = 1'b0; ramp = 1'b0; tick();
      chk("t5_n", got.size(), 1);
      chk("t5_d", got_d(0), 1); chk("t5_l", got_l(0), 1);
`endif
      tick(); tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
